// File: rtl/npu_sram_pkg.sv
// Shared definitions for the NPU memory-bus scratchpad responder.
package npu_sram_pkg;
  localparam int NPU_DATA_W = 16;
  localparam int NPU_ADDR_W = 32;
  localparam logic [NPU_DATA_W-1:0] NPU_MEM_ERR_RDATA = 16'h0000;

  // One read-pipe entry: valid strobe, range error, payload.
  typedef struct packed {
    logic                  vld;
    logic                  err;
    logic [NPU_DATA_W-1:0] data;
  } rd_ent_t;
endpackage

// File: rtl/npu_sram_rd_pipe.sv
// RD_LAT-deep valid/err/data delay line; stage 0 loads at the request edge,
// the last stage drives the bus outputs.
module npu_sram_rd_pipe
  import npu_sram_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_ent_t in_ent,
  output rd_ent_t out_ent
);
  logic [RD_LAT-1:0]                 vld_pipe;
  logic [RD_LAT-1:0]                 err_pipe;
  logic [RD_LAT-1:0][NPU_DATA_W-1:0] data_pipe;

  // Data only advances behind a valid entry so the output holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      err_pipe  <= '0;
      data_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_ent.vld;
      err_pipe[0] <= in_ent.err;
      if (in_ent.vld) data_pipe[0] <= in_ent.data;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        err_pipe[s] <= err_pipe[s-1];
        if (vld_pipe[s-1]) data_pipe[s] <= data_pipe[s-1];
      end
    end
  end

  assign out_ent.vld  = vld_pipe[RD_LAT-1];
  assign out_ent.err  = err_pipe[RD_LAT-1];
  assign out_ent.data = data_pipe[RD_LAT-1];
endmodule

// File: rtl/npu_sram_responder.sv
// Scratchpad terminating the single-port NPU memory bus: array, range check,
// read latency pipe and saturating access counters.
module npu_sram_responder
  import npu_sram_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      mem_addr,
  input  logic [15:0]      mem_wdata,
  input  logic             mem_we,
  input  logic             mem_ce,
  output logic [15:0]      mem_rdata,
  output logic             mem_rvalid,
  output logic             mem_err,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  input  logic             cnt_clr
);
  localparam int AW = $clog2(DEPTH);

  logic [NPU_DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]         idx;
  logic                  in_range;
  logic                  rd_acc;
  logic                  wr_acc;
  rd_ent_t               req_ent;
  rd_ent_t               rsp_ent;

  // Full 32-bit compare: aliasing high addresses onto the array is an error.
  assign in_range = (mem_addr < NPU_ADDR_W'(DEPTH));
  assign idx      = mem_addr[AW-1:0];
  assign rd_acc   = mem_ce & ~mem_we & in_range;
  assign wr_acc   = mem_ce &  mem_we & in_range;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[idx] <= mem_wdata;
  end

  always_comb begin
    req_ent.vld  = mem_ce & ~mem_we;
    req_ent.err  = mem_ce & ~in_range;
    req_ent.data = in_range ? mem[idx] : NPU_MEM_ERR_RDATA;
  end

  npu_sram_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_ent  (req_ent),
    .out_ent (rsp_ent)
  );

  assign mem_rdata  = rsp_ent.data;
  assign mem_rvalid = rsp_ent.vld;
  assign mem_err    = rsp_ent.err;

  // Clear wins over increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (cnt_clr) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_acc && !(&rd_count)) rd_count <= rd_count + 1'b1;
      if (wr_acc && !(&wr_count)) wr_count <= wr_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_npu_sram_responder.sv
// Directed bench: three responders (RD_LAT 1/2/3) share one request stream.
module tb_npu_sram_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] mem_addr = '0;
  logic [15:0] mem_wdata = '0;
  logic        mem_we = 1'b0;
  logic        mem_ce = 1'b0;
  logic        cnt_clr = 1'b0;

  logic [15:0] rdata1, rdata2, rdata3;
  logic        rvalid1, rvalid2, rvalid3;
  logic        err1, err2, err3;
  logic [3:0]  rc1, wc1;
  logic [31:0] rc2, wc2, rc3, wc3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  npu_sram_responder #(.DEPTH(1024), .RD_LAT(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_ce(mem_ce), .mem_rdata(rdata1), .mem_rvalid(rvalid1),
    .mem_err(err1), .rd_count(rc1), .wr_count(wc1), .cnt_clr(cnt_clr));

  npu_sram_responder #(.DEPTH(1024), .RD_LAT(2), .CNT_W(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_ce(mem_ce), .mem_rdata(rdata2), .mem_rvalid(rvalid2),
    .mem_err(err2), .rd_count(rc2), .wr_count(wc2), .cnt_clr(cnt_clr));

  npu_sram_responder #(.DEPTH(1024), .RD_LAT(3), .CNT_W(32)) dut3 (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_ce(mem_ce), .mem_rdata(rdata3), .mem_rvalid(rvalid3),
    .mem_err(err3), .rd_count(rc3), .wr_count(wc3), .cnt_clr(cnt_clr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic ce, input logic we, input logic [31:0] a, input logic [15:0] d);
    mem_ce = ce; mem_we = we; mem_addr = a; mem_wdata = d;
  endtask

  initial begin
    // Reset
    #3 rst_n = 1'b0;
    cyc(); cyc();
    chk("rst_rdata", 32'(rdata1), 32'h0);
    chk("rst_rvalid", 32'(rvalid1), 32'h0);
    chk("rst_err", 32'(err1), 32'h0);
    chk("rst_rc", 32'(rc1), 32'h0);
    chk("rst_wc", 32'(wc1), 32'h0);
    chk("rst_rvalid3", 32'(rvalid3), 32'h0);
    rst_n = 1'b1;
    cyc();

    // RD_LAT=1 read-after-write
    req(1, 1, 32'd5, 16'h1234); cyc();
    chk("raw_wr_rvalid", 32'(rvalid1), 32'h0);
    chk("raw_wc", 32'(wc1), 32'd1);
    req(1, 0, 32'd5, 16'h0); cyc();
    chk("raw_rdata", 32'(rdata1), 32'h1234);
    chk("raw_rvalid", 32'(rvalid1), 32'h1);
    chk("raw_rc", 32'(rc1), 32'd1);
    req(0, 0, 32'd0, 16'h0); cyc();
    chk("raw_rvalid_off", 32'(rvalid1), 32'h0);
    chk("raw_rdata_hold", 32'(rdata1), 32'h1234);
    cyc(); cyc(); cyc();

    // RD_LAT=3 back-to-back reads
    for (int i = 0; i < 4; i++) begin
      req(1, 1, 32'(i), 16'hA000 + 16'(i)); cyc();
    end
    req(1, 0, 32'd0, 16'h0); cyc();
    chk("b2b_lat1_first", 32'(rdata1), 32'hA000);
    req(1, 0, 32'd1, 16'h0); cyc();
    chk("b2b_early_rvalid3", 32'(rvalid3), 32'h0);
    req(1, 0, 32'd2, 16'h0); cyc();
    chk("b2b_rvalid3_0", 32'(rvalid3), 32'h1);
    chk("b2b_rdata3_0", 32'(rdata3), 32'hA000);
    req(1, 0, 32'd3, 16'h0); cyc();
    chk("b2b_rvalid3_1", 32'(rvalid3), 32'h1);
    chk("b2b_rdata3_1", 32'(rdata3), 32'hA001);
    req(0, 0, 32'd0, 16'h0); cyc();
    chk("b2b_rvalid3_2", 32'(rvalid3), 32'h1);
    chk("b2b_rdata3_2", 32'(rdata3), 32'hA002);
    cyc();
    chk("b2b_rvalid3_3", 32'(rvalid3), 32'h1);
    chk("b2b_rdata3_3", 32'(rdata3), 32'hA003);
    cyc();
    chk("b2b_rvalid3_end", 32'(rvalid3), 32'h0);
    chk("b2b_rdata3_hold", 32'(rdata3), 32'hA003);
    chk("b2b_rc1", 32'(rc1), 32'd5);
    chk("b2b_wc1", 32'(wc1), 32'd5);
    chk("b2b_rc3", rc3, 32'd5);

    // Out-of-range accesses
    req(1, 1, 32'd1024, 16'hBEEF); cyc();
    chk("oor_wr_err", 32'(err1), 32'h1);
    chk("oor_wr_rvalid", 32'(rvalid1), 32'h0);
    chk("oor_wr_rdata_hold", 32'(rdata1), 32'hA003);
    chk("oor_wr_wc", 32'(wc1), 32'd5);
    req(1, 0, 32'd1024, 16'h0); cyc();
    chk("oor_rd_err", 32'(err1), 32'h1);
    chk("oor_rd_rvalid", 32'(rvalid1), 32'h1);
    chk("oor_rd_rdata", 32'(rdata1), 32'h0);
    chk("oor_rd_rc", 32'(rc1), 32'd5);
    req(1, 0, 32'd0, 16'h0); cyc();
    chk("oor_a0_rdata", 32'(rdata1), 32'hA000);
    chk("oor_a0_err", 32'(err1), 32'h0);
    chk("oor_a0_rc", 32'(rc1), 32'd6);
    chk("oor_wr_err3", 32'(err3), 32'h1);
    chk("oor_wr_rvalid3", 32'(rvalid3), 32'h0);
    req(1, 0, 32'h0001_0005, 16'h0); cyc();
    chk("oor_hi_err", 32'(err1), 32'h1);
    chk("oor_hi_rdata", 32'(rdata1), 32'h0);
    chk("oor_rd_err3", 32'(err3), 32'h1);
    chk("oor_rd_rvalid3", 32'(rvalid3), 32'h1);
    chk("oor_rd_rdata3", 32'(rdata3), 32'h0);
    req(0, 0, 32'd0, 16'h0); cyc();
    chk("oor_idle_err", 32'(err1), 32'h0);
    chk("oor_a0_rdata3", 32'(rdata3), 32'hA000);
    chk("oor_a0_err3", 32'(err3), 32'h0);
    chk("oor_rc1_final", 32'(rc1), 32'd6);
    cyc(); cyc(); cyc(); cyc();

    // Reset with a read in flight
    req(1, 0, 32'd1, 16'h0); cyc();
    req(0, 0, 32'd0, 16'h0);
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rstmid_rvalid2", 32'(rvalid2), 32'h0);
      chk("rstmid_err2", 32'(err2), 32'h0);
      chk("rstmid_rdata2", 32'(rdata2), 32'h0);
      chk("rstmid_rvalid3", 32'(rvalid3), 32'h0);
    end
    chk("rstmid_rc1", 32'(rc1), 32'h0);

    // Counter saturation (4-bit) and clear priority
    for (int i = 0; i < 14; i++) begin
      req(1, 1, 32'd7, 16'(i)); cyc();
    end
    chk("sat_wc14", 32'(wc1), 32'd14);
    req(1, 1, 32'd7, 16'h0F0F); cyc();
    chk("sat_wc15", 32'(wc1), 32'd15);
    req(1, 1, 32'd7, 16'h0F0F); cyc();
    chk("sat_wc_hold", 32'(wc1), 32'd15);
    chk("sat_wc2_free", wc2, 32'd16);
    cnt_clr = 1'b1;
    req(1, 1, 32'd7, 16'h0F0F); cyc();
    chk("clr_wc", 32'(wc1), 32'd0);
    chk("clr_wc2", wc2, 32'd0);
    cnt_clr = 1'b0;
    req(1, 1, 32'd7, 16'h0F0F); cyc();
    chk("clr_wc_after", 32'(wc1), 32'd1);

    // Idle bus holds last read data
    req(1, 1, 32'd9, 16'h5A5A); cyc();
    req(1, 0, 32'd9, 16'h0); cyc();
    chk("idle_rd_rdata", 32'(rdata1), 32'h5A5A);
    chk("idle_rd_rvalid", 32'(rvalid1), 32'h1);
    req(0, 0, 32'd0, 16'h0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_rvalid", 32'(rvalid1), 32'h0);
      chk("idle_rdata", 32'(rdata1), 32'h5A5A);
    end
    chk("idle_rdata3", 32'(rdata3), 32'h5A5A);
    chk("idle_rc1", 32'(rc1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
